// File: rtl/uart_apb_tx_sequencer_if.sv
// APB bundle between the UART TX sequencer (master) and the 16550 slave.
interface uart_apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready
  );
endinterface

// File: rtl/uart_apb_tx_sequencer.sv
// APB master: configures a 16550 UART, then drains a byte FIFO into THR.
// UART_TX_SEQ_BURST_EN: adds an FCR write and up-to-16-byte bursts per poll.
module uart_apb_tx_sequencer #(
  parameter logic [31:0] UART_BASE  = 32'h1000_0000,
  parameter logic [15:0] DIVISOR    = 16'h0001,
  parameter logic [7:0]  LCR_VAL    = 8'h03,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       init_done,
  output logic       busy,
  uart_apb_if.master apb
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_FCR, S_DLAB, S_DLL, S_DLM, S_LCR, S_IDLE, S_POLL, S_SEND
  } state_e;

  typedef struct packed {
    logic       wr;
    logic [2:0] off;
    logic [7:0] dat;
  } xfer_t;

`ifdef UART_TX_SEQ_BURST_EN
  localparam state_e S_FIRST = S_FCR;
`else
  localparam state_e S_FIRST = S_DLAB;
`endif

  function automatic xfer_t xfer(state_e s, logic [7:0] hd);
    case (s)
      S_FCR:   xfer = '{1'b1, 3'd2, 8'h07};
      S_DLAB:  xfer = '{1'b1, 3'd3, 8'h80};
      S_DLL:   xfer = '{1'b1, 3'd0, DIVISOR[7:0]};
      S_DLM:   xfer = '{1'b1, 3'd1, DIVISOR[15:8]};
      S_LCR:   xfer = '{1'b1, 3'd3, LCR_VAL};
      S_POLL:  xfer = '{1'b0, 3'd5, 8'h00};
      S_SEND:  xfer = '{1'b1, 3'd0, hd};
      default: xfer = '{1'b0, 3'd0, 8'h00};
    endcase
  endfunction

  logic [7:0]  mem_q [FIFO_DEPTH];
  state_e      state_q, state_d, nxt;
  logic        psel_q, psel_d, penable_q, penable_d;
  logic        pwrite_q, pwrite_d, init_done_q, init_done_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
`ifdef UART_TX_SEQ_BURST_EN
  logic [4:0]  burst_q, burst_d;
`endif
  logic        push, pop, done, go, full;
  logic [7:0]  head;
  xfer_t       xf;
  logic        unused_prdata;

  assign unused_prdata = ^{apb.prdata[31:6], apb.prdata[4:0]};

  always_comb begin
    full      = (count_q == FULL);
    push      = tx_valid & ~full;
    done      = psel_q & penable_q & apb.pready;
    pop       = done & (state_q == S_SEND);
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    head      = mem_q[rd_ptr_d];
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    init_done_d = init_done_q;
`ifdef UART_TX_SEQ_BURST_EN
    burst_d   = burst_q;
`endif
    nxt = state_q;
    go  = 1'b0;
    if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      case (state_q)
        S_FCR:  begin nxt = S_DLAB; go = 1'b1; end
        S_DLAB: begin nxt = S_DLL;  go = 1'b1; end
        S_DLL:  begin nxt = S_DLM;  go = 1'b1; end
        S_DLM:  begin nxt = S_LCR;  go = 1'b1; end
        S_LCR: begin
          init_done_d = 1'b1;
          go  = (count_d != '0);
          nxt = go ? S_POLL : S_IDLE;
        end
        S_POLL: begin
          go  = 1'b1;
          nxt = apb.prdata[5] ? S_SEND : S_POLL;
`ifdef UART_TX_SEQ_BURST_EN
          burst_d = 5'd0;
`endif
        end
        S_SEND: begin
`ifdef UART_TX_SEQ_BURST_EN
          burst_d = burst_q + 5'd1;
          // chain only when the next head is already stored
          if (count_q > ONE && burst_q != 5'd15) begin
            nxt = S_SEND;
            go  = 1'b1;
          end else begin
            go  = (count_d != '0);
            nxt = go ? S_POLL : S_IDLE;
          end
`else
          go  = (count_d != '0);
          nxt = go ? S_POLL : S_IDLE;
`endif
        end
        default: ;
      endcase
    end else if (!psel_q) begin
      if (state_q == S_IDLE) begin
        if (count_q != '0) begin
          nxt = S_POLL;
          go  = 1'b1;
        end
      end else begin
        go = 1'b1;
      end
    end
    xf = xfer(nxt, head);
    if (go) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = xf.wr;
      paddr_d   = UART_BASE + {29'd0, xf.off};
      pwdata_d  = {4{xf.dat}};
      pstrb_d   = xf.wr ? (4'b0001 << xf.off[1:0]) : 4'b0000;
    end
    state_d = nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FIRST;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      init_done_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
`ifdef UART_TX_SEQ_BURST_EN
      burst_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      init_done_q <= init_done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
`ifdef UART_TX_SEQ_BURST_EN
      burst_q     <= burst_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx_ready    = ~full;
  assign init_done   = init_done_q;
  assign busy        = (count_q != '0) | psel_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
endmodule

// File: tb/tb_uart_apb_tx_sequencer.sv
// Scoreboard bench for uart_apb_tx_sequencer with a simple 16550 APB slave model.
module tb_uart_apb_tx_sequencer;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_TX_SEQ_BURST_EN
  localparam int INIT_CYC = 11;
`else
  localparam int INIT_CYC = 9;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, init_done, busy;
  logic       pready_en;
  logic [7:0] lsr_cur = 8'h60;

  uart_apb_if apb();
  assign apb.pready = pready_en;
  assign apb.prdata = {4{lsr_cur}};

  always #5 clock = ~clock;

  uart_apb_tx_sequencer #(
    .UART_BASE(BASE), .DIVISOR(16'h0102),
    .LCR_VAL(8'h03), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .init_done(init_done),
    .busy(busy), .apb(apb)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] lsr_q[$];
  int         nchk = 0;
  int         nbad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic exp_wr(logic [2:0] off, logic [7:0] b, logic [3:0] s);
    txn_t t;
    t.wr = 1'b1; t.addr = BASE + {29'd0, off};
    t.data = {4{b}}; t.strb = s;
    exp_q.push_back(t);
  endtask

  task automatic exp_rd();
    txn_t t;
    t.wr = 1'b0; t.addr = BASE + 32'd5;
    t.data = '0; t.strb = 4'b0000;
    exp_q.push_back(t);
  endtask

  task automatic exp_byte(logic [7:0] b);
    exp_rd();
    exp_wr(3'd0, b, 4'b0001);
  endtask

  task automatic exp_init();
`ifdef UART_TX_SEQ_BURST_EN
    exp_wr(3'd2, 8'h07, 4'b0100);
`endif
    exp_wr(3'd3, 8'h80, 4'b1000);
    exp_wr(3'd0, 8'h02, 4'b0001);
    exp_wr(3'd1, 8'h01, 4'b0010);
    exp_wr(3'd3, 8'h03, 4'b1000);
  endtask

  task automatic send_byte(logic [7:0] b);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    do begin
      @(negedge clock);
      n++;
    end while (!tx_ready && n < 200);
    check("push_accepted", tx_ready, 1);
    @(posedge clock); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check({nm, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
  endtask

  // monitor: stability during ACCESS and scoreboard compare on completion
  initial begin
    txn_t e;
    logic [31:0] sa, sd;
    forever begin
      @(negedge clock);
      if (apb.psel && !apb.penable) begin
        sa = apb.paddr;
        sd = apb.pwdata;
      end else if (apb.psel && apb.penable) begin
        check("stable_addr", apb.paddr, sa);
        check("stable_data", apb.pwdata, sd);
        if (apb.pready) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nbad++;
            $display("FAIL unexpected_txn actual_addr=%h write=%0d required=none",
                     apb.paddr, apb.pwrite);
          end else begin
            e = exp_q.pop_front();
            check("txn_write", 32'(apb.pwrite), 32'(e.wr));
            check("txn_addr", apb.paddr, e.addr);
            check("txn_strb", 32'(apb.pstrb), 32'(e.strb));
            if (e.wr) check("txn_data", apb.pwdata, e.data);
          end
          if (!apb.pwrite) begin
            @(posedge clock); #1;
            if (lsr_q.size() != 0) void'(lsr_q.pop_front());
            lsr_cur = (lsr_q.size() != 0) ? lsr_q[0] : 8'h60;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; pready_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_psel", apb.psel, 0);
    check("rst_penable", apb.penable, 0);
    check("rst_pwrite", apb.pwrite, 0);
    check("rst_paddr", apb.paddr, 0);
    check("rst_pwdata", apb.pwdata, 0);
    check("rst_pstrb", apb.pstrb, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);

    exp_init();
    reset = 1'b0;
    for (int k = 1; k <= INIT_CYC; k++) begin
      @(posedge clock); #1;
      if (k == INIT_CYC - 1) check("init_done_early", init_done, 0);
      if (k == INIT_CYC) check("init_done_cycle", init_done, 1);
    end
    wait_drain("init");
    check("init_busy", busy, 0);

`ifdef UART_TX_SEQ_BURST_EN
    exp_rd();
    for (int i = 0; i < 16; i++) exp_wr(3'd0, 8'h20 + 8'(i), 4'b0001);
    exp_rd();
    for (int i = 16; i < 20; i++) exp_wr(3'd0, 8'h20 + 8'(i), 4'b0001);
    for (int i = 0; i < 20; i++) send_byte(8'h20 + 8'(i));
    wait_drain("burst");
    check("burst_busy", busy, 0);
`else
    exp_rd();
    exp_wr(3'd0, 8'h41, 4'b0001);
    send_byte(8'h41);
    wait_drain("single");
    check("single_busy", busy, 0);

    lsr_q = '{8'h00, 8'h00, 8'h00, 8'h60};
    lsr_cur = 8'h00;
    repeat (4) exp_rd();
    exp_wr(3'd0, 8'h5A, 4'b0001);
    exp_byte(8'h5B);
    send_byte(8'h5A);
    send_byte(8'h5B);
    wait_drain("thre_poll");

    pready_en = 1'b0;
    for (int i = 0; i < 9; i++) exp_byte(8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    check("full_tx_ready", tx_ready, 0);
    check("full_busy", busy, 1);
    fork
      send_byte(8'h18);
      begin
        repeat (4) @(posedge clock);
        #1;
        pready_en = 1'b1;
      end
    join
    wait_drain("full_fifo");
    check("full_after_busy", busy, 0);

    reset = 1'b1;
    @(posedge clock); #1;
    exp_wr(3'd3, 8'h80, 4'b1000);
    exp_wr(3'd0, 8'h02, 4'b0001);
    reset = 1'b0;
    send_byte(8'hEE);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!(apb.psel && !apb.penable && apb.paddr == BASE + 32'd1) && n < 50);
    pready_en = 1'b0;
    @(posedge clock); #1;
    check("dlm_access", apb.penable, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_psel", apb.psel, 0);
    check("mid_rst_penable", apb.penable, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_pending", exp_q.size(), 0);
    pready_en = 1'b1;
    exp_init();
    reset = 1'b0;
    wait_drain("reinit");
    check("reinit_done", init_done, 1);
    check("reinit_busy", busy, 0);
    exp_byte(8'h77);
    send_byte(8'h77);
    wait_drain("post_reinit");
`endif

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
